// File: rtl/cache_miss_controller.sv
// cache_miss_controller
//   Direct-mapped, write-through, no-write-allocate cache controller with one
//   word per line. It sequences CPU loads and stores against the tag, valid
//   and data arrays. It runs the refill and write-through transactions to main
//   memory over a req/ack handshake. It keeps saturating hit and miss counters.
//
// Ports
//   clk, reset              : system clock (rising edge), async active-low reset
//   cpu_req/we/addr/wdata   : CPU request, accepted when cpu_req && cpu_ready
//   cpu_ready               : high only while idle
//   cpu_valid/hit/rdata     : one-cycle completion pulse with hit flag and read data
//   mem_req/we/addr/wdata   : memory request, held until mem_ack
//   mem_ack/rdata           : one-cycle memory completion, read data in the same cycle
//   hit_count/miss_count    : 16-bit saturating performance counters
module cache_miss_controller #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic                  cpu_valid,
  output logic                  cpu_hit,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int LINES = 2**INDEX_WIDTH;
  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH;

  typedef enum logic [2:0] {
    IDLE, LOOKUP, REFILL, WRITE_MEM, RESPOND
  } state_t;

  state_t                  r_state;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [LINES-1:0]        r_valid;
  logic [TAG_W-1:0]        r_tag  [LINES];
  logic [DATA_WIDTH-1:0]   r_data [LINES];

  logic                    r_ready;
  logic                    r_cpu_valid;
  logic                    r_cpu_hit;
  logic [DATA_WIDTH-1:0]   r_cpu_rdata;
  logic                    r_mem_req;
  logic                    r_mem_we;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [DATA_WIDTH-1:0]   r_mem_wdata;
  logic [15:0]             r_hit_cnt;
  logic [15:0]             r_miss_cnt;

  logic [INDEX_WIDTH-1:0]  w_idx;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_hit;
  logic                    w_wr_hit;
  logic                    w_refill_done;
  logic                    w_arr_we;
  logic [DATA_WIDTH-1:0]   w_arr_wdata;

  // Lookups always use the latched request address.
  assign w_idx = r_addr[INDEX_WIDTH-1:0];
  assign w_tag = r_addr[ADDR_WIDTH-1:INDEX_WIDTH];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // The data array is written on a store hit (no allocate on a store miss)
  // and on a refill return. Only a refill rewrites the tag. During reset the
  // state is IDLE, so neither write strobe can fire.
  assign w_wr_hit      = (r_state == LOOKUP) && r_we && w_hit;
  assign w_refill_done = (r_state == REFILL) && mem_ack;
  assign w_arr_we      = w_wr_hit || w_refill_done;
  assign w_arr_wdata   = w_refill_done ? mem_rdata : r_wdata;

  // The tag and data arrays are not reset. The valid bits decide what counts.
  always_ff @(posedge clk) begin
    if (w_arr_we) begin
      r_data[w_idx] <= w_arr_wdata;
      if (w_refill_done) r_tag[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_valid     <= '0;
      r_ready     <= 1'b1;
      r_cpu_valid <= 1'b0;
      r_cpu_hit   <= 1'b0;
      r_cpu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_ready <= 1'b0;
            r_state <= LOOKUP;
          end
        end

        LOOKUP: begin
          if (w_hit) begin
            r_cpu_hit <= 1'b1;
            if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
          end else begin
            r_cpu_hit <= 1'b0;
            if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
          end
          r_mem_addr <= r_addr;
          if (r_we) begin
            // Write-through: a store goes to memory on a hit and on a miss.
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_wdata <= r_wdata;
            r_state     <= WRITE_MEM;
          end else if (w_hit) begin
            r_cpu_rdata <= r_data[w_idx];
            r_cpu_valid <= 1'b1;
            r_state     <= RESPOND;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= REFILL;
          end
        end

        REFILL: begin
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_cpu_rdata    <= mem_rdata;
            r_cpu_hit      <= 1'b0;
            r_mem_req      <= 1'b0;
            r_cpu_valid    <= 1'b1;
            r_state        <= RESPOND;
          end
        end

        WRITE_MEM: begin
          if (mem_ack) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_cpu_valid <= 1'b1;
            r_state     <= RESPOND;
          end
        end

        RESPOND: begin
          r_cpu_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end

        default: begin
          r_cpu_valid <= 1'b0;
          r_mem_req   <= 1'b0;
          r_mem_we    <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign cpu_ready  = r_ready;
  assign cpu_valid  = r_cpu_valid;
  assign cpu_hit    = r_cpu_hit;
  assign cpu_rdata  = r_cpu_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

endmodule
